// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_regfile
//  Purpose  : APB completer serving a bank of DEPTH 32-bit registers on one
//             Pselx line. Decodes setup/access phases, optionally inserts
//             WAIT_CYCLES wait states through Pready, returns registered read
//             data on Prdata and flags misaligned/out-of-range accesses on
//             Pslverr.
//  Feature  : APB_SLV_WAIT_EN -- when defined, the wait-state down-counter is
//             built and WAIT_CYCLES is honoured; otherwise every access phase
//             completes in one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
  parameter int SEL_IDX     = 0,
  parameter int DEPTH       = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  // Index width actually needed to address the bank (at least one bit).
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [10:0] DEPTH_W = 11'(DEPTH);

`ifdef APB_SLV_WAIT_EN
  localparam int EFF_WAIT = WAIT_CYCLES;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`else
  // Without the wait feature WAIT_CYCLES has no effect on timing.
  localparam int EFF_WAIT = 0 * WAIT_CYCLES;
`endif
  localparam bit ZERO_WAIT = (EFF_WAIT == 0);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              err_q, err_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [31:0]       mem_q [DEPTH];
  logic              mem_we;
`ifdef APB_SLV_WAIT_EN
  logic [3:0]        cnt_q, cnt_d;
`endif

  // Address decode of the live bus (used at the setup edge).
  logic              sel;
  logic [9:0]        setup_idx;
  logic              setup_err;
  logic [31:0]       setup_rd;
  logic [31:0]       acc_rd;
  logic              cnt_zero;

  assign sel       = Pselx[SEL_IDX];
  assign setup_idx = Paddr[11:2];
  assign setup_err = (Paddr[1:0] != 2'b00) || ({1'b0, setup_idx} >= DEPTH_W);
  // The bank is only indexed when the access is in range, so the truncated
  // index always lands on a real entry.
  assign setup_rd  = setup_err ? 32'h0 : mem_q[setup_idx[AW-1:0]];
  assign acc_rd    = err_q ? 32'h0 : mem_q[idx_q];

`ifdef APB_SLV_WAIT_EN
  assign cnt_zero = (cnt_q == 4'd0);
`else
  assign cnt_zero = 1'b1;
`endif

  // Upper address bits and the other peripheral selects are not decoded here.
  logic unused_bits;
  assign unused_bits = ^{Paddr[31:12], Pselx};

  // Next-state and output logic for the IDLE/ACCESS handshake.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    mem_we    = 1'b0;
`ifdef APB_SLV_WAIT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel && !Penable) begin
          state_d = ACCESS;
          idx_d   = setup_idx[AW-1:0];
          err_d   = setup_err;
          write_d = Pwrite;
          wdata_d = Pwdata;
          if (ZERO_WAIT) begin
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            if (!Pwrite) prdata_d = setup_rd;
          end
`ifdef APB_SLV_WAIT_EN
          else begin
            cnt_d = CNT_LOAD;
          end
`endif
        end
      end
      ACCESS: begin
        if (!sel) begin
          // Abort: drop the transfer without touching the bank.
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (pready_q) begin
          // Completion cycle: commit a good write, then release the bus.
          mem_we    = write_q && !err_q;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          state_d   = IDLE;
        end else if (cnt_zero) begin
          pready_d  = 1'b1;
          pslverr_d = err_q;
          if (!write_q) prdata_d = acc_rd;
        end
`ifdef APB_SLV_WAIT_EN
        else begin
          cnt_d = cnt_q - 4'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= 32'h0;
      prdata_q  <= 32'h0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
`ifdef APB_SLV_WAIT_EN
      cnt_q     <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
`ifdef APB_SLV_WAIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Register bank: cleared on reset, written only in a good completion cycle.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign Prdata  = prdata_q;
  assign Pready  = pready_q;
  assign Pslverr = pslverr_q;

endmodule
`default_nettype wire

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer (slave) that terminates one `Pselx` line from the AHB-to-APB bridge controller and serves a bank of 32-bit registers. It decodes setup/access phases and inserts a configurable number of wait states through `Pready`. It returns read data on `Prdata` and flags bad accesses on `Pslverr`. One instance hangs off each peripheral select of the bridge.

## Interface
- `SEL_IDX`, default 0: which bit of `Pselx` selects this instance (0..2).
- `DEPTH`, default 8: number of 32-bit registers (1..1024).
- `WAIT_CYCLES`, default 2: wait states inserted per access (0..15). Only honoured when `APB_SLV_WAIT_EN` is defined.

Ports:
- `Hclk` in 1: single clock; all state changes on the rising edge.
- `Hresetn` in 1: asynchronous, active-low reset.
- `Pselx` in 3: peripheral selects; `sel = Pselx[SEL_IDX]`.
- `Penable` in 1: APB access-phase indicator.
- `Pwrite` in 1: 1 = write, 0 = read.
- `Paddr` in 32: byte address; only `Paddr[11:0]` (the offset) is decoded.
- `Pwdata` in 32: write data.
- `Prdata` out 32: read data; registered.
- `Pready` out 1: transfer complete; registered.
- `Pslverr` out 1: error response, valid only while `Pready`=1; registered.

## Operation
- **Register index:** `idx = offset[11:2]`.
- **Error condition:** `err = (offset[1:0] != 0) || (idx >= DEPTH)`.
- **FSM states:** IDLE, ACCESS.
- **IDLE:**
  - On `sel & !Penable` (setup phase), latch `idx`, `err`, `Pwrite` and `Pwdata`, then go to ACCESS.
  - If the effective wait count is 0, set `Pready`<=1 at the same edge. Also set `Pslverr`<=`err`, and for a read set `Prdata`<=(err ? 0 : mem[idx]).
  - Otherwise load `cnt`<=effective_wait-1.
- **ACCESS with `Pready`=0:**
  - If `cnt`==0: `Pready`<=1; load `Pslverr` and, for a read, `Prdata` as above.
  - Else `cnt`<=`cnt`-1.
- **ACCESS with `Pready`=1 (completion cycle):**
  - If latched write and !err: `mem[idx]`<=latched `Pwdata` at this edge.
  - `Pready`<=0, `Pslverr`<=0, go to IDLE.
- **Data handling:**
  - Writes use the data latched in the setup phase.
  - `Prdata` holds its last loaded value and is not cleared after a transfer.
  - Writes never alter `Prdata`.
- **Abort:** if `sel` drops while in ACCESS, return to IDLE immediately. No write occurs and `Pready`/`Pslverr` are cleared.
- **Errored writes:** leave memory unchanged; errored reads return 0.

## Timing
- **Reset values:**
  - `Prdata`=0, `Pready`=0, `Pslverr`=0.
  - State=IDLE, `cnt`=0.
  - All `mem` entries=0.
- **Access length:**
  - Access phase lasts W+1 cycles, where W = effective wait count.
  - `Pready` is low for the first W access cycles and high for exactly one cycle.
- **Back-to-back transfers:**
  - A new setup phase in the cycle immediately after the completion cycle is accepted, giving zero idle cycles.
  - Consecutive transfers each take W+2 cycles including setup.
- **Read-after-write:** a read to the same index issued back-to-back after a write returns the new data.
- **Reset mid-operation:** asynchronous reset forces all values above immediately. An in-flight write is dropped.
- **Select on other bits:** selects on other `Pselx` bits are ignored in every state.

## Configuration
- Feature macro: `APB_SLV_WAIT_EN`.
- **Defined:** effective wait count = `WAIT_CYCLES`; the down-counter is present.
- **Undefined:**
  - The counter is not built and effective wait = 0.
  - `Pready` rises at the setup edge, so every access phase is exactly one cycle.
  - `WAIT_CYCLES` is ignored.

## Test plan
- **Reset:** assert `Hresetn`=0 mid-transfer. Expect `Pready`/`Pslverr`/`Prdata`=0 with no clock edge, then a read of offset 0x004 returns 0.
- **Write then read, macro on, `WAIT_CYCLES`=2:**
  - Write 0x1234_5678 to offset 0x008: `Pready` low for 2 access cycles, high on the 3rd.
  - Read offset 0x008 back-to-back: `Prdata`=0x1234_5678 with `Pready`=1 and `Pslverr`=0.
- **Error cases, `DEPTH`=8:**
  - Write to offset 0x020 → `Pslverr`=1 on the `Pready` cycle and memory unchanged.
  - Read offset 0x006 → `Pslverr`=1 and `Prdata`=0.
- **Macro off:** write 0x8765_4321 to 0x00C then read it. `Pready`=1 in the first access cycle of each transfer; total 2 cycles per transfer; read returns 0x8765_4321.
- **Abort and ignored selects:**
  - Drop `sel` during the wait cycles of a write of 0xDEAD_BEEF to 0x004: FSM returns to IDLE and a subsequent read of 0x004 returns the old value.
  - Toggling a non-matching `Pselx` bit produces no response.
